// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_ADDR_WIDTH    = 9;
   localparam int DEF_THRESH_OFFSET = 4;

   // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with registered read port; shaped to map onto SB_RAM40_4K.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy, threshold flags, sticky error flags and flush.
// Define FIFO_FWFT_EN to build the first-word-fall-through output variant.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - DEF_THRESH_OFFSET,
   parameter int AEMPTY_THRESH = DEF_THRESH_OFFSET
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic                               we,
   input  logic [DATA_WIDTH-1:0]              d,
   input  logic                               re,
   output logic [DATA_WIDTH-1:0]              q,
   output logic                               q_valid,
   output logic                               empty,
   output logic                               full,
   output logic                               almost_full,
   output logic                               almost_empty,
   output logic [count_width(ADDR_WIDTH)-1:0] count,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int            CW       = count_width(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(1 << ADDR_WIDTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [CW-1:0]         wptr, rptr, count_nxt;
   logic [DATA_WIDTH-1:0] rdata_p1;
   logic                  vld_p1, vld_p1_nxt, q_valid_nxt, empty_nxt;
   logic                  wr_acc, pop, fetch, load_q, rd_err;

   always_comb begin
      wr_acc = we & ~full & ~clr;
`ifdef FIFO_FWFT_EN
      // Prefetch keeps at most one word in the RAM output register behind q.
      pop         = re & q_valid & ~clr;
      load_q      = vld_p1 & (~q_valid | pop);
      fetch       = (wptr != rptr) & (~vld_p1 | load_q) & ~clr;
      vld_p1_nxt  = fetch | (vld_p1 & ~load_q);
      q_valid_nxt = load_q | (q_valid & ~pop);
      rd_err      = re & ~q_valid;
`else
      pop         = re & ~empty & ~clr;
      load_q      = vld_p1;
      fetch       = pop;
      vld_p1_nxt  = pop;
      q_valid_nxt = vld_p1;
      rd_err      = re & empty;
`endif
      count_nxt = count;
      if (wr_acc & ~pop)
         count_nxt = count + CW'(1);
      else if (pop & ~wr_acc)
         count_nxt = count - CW'(1);
`ifdef FIFO_FWFT_EN
      empty_nxt = ~q_valid_nxt;
`else
      empty_nxt = (count_nxt == '0);
`endif
   end

   // Stage p0 -> p1: RAM write and registered RAM read
   fifo_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr_acc),
      .waddr(wptr[ADDR_WIDTH-1:0]),
      .wdata(d),
      .re   (fetch),
      .raddr(rptr[ADDR_WIDTH-1:0]),
      .rdata(rdata_p1)
   );

   // Stage p1 -> output: q register, pointers and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         vld_p1       <= 1'b0;
         q            <= '0;
         q_valid      <= 1'b0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (clr) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         vld_p1       <= 1'b0;
         q_valid      <= 1'b0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + CW'(1);
         if (fetch)  rptr <= rptr + CW'(1);
         if (load_q) q <= rdata_p1;
         if (we & full) overflow <= 1'b1;
         if (rd_err) underflow <= 1'b1;
         count        <= count_nxt;
         vld_p1       <= vld_p1_nxt;
         q_valid      <= q_valid_nxt;
         empty        <= empty_nxt;
         full         <= (count_nxt == DEPTH_C);
         almost_full  <= (count_nxt >= AFULL_C);
         almost_empty <= (count_nxt <= AEMPTY_C);
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based occupancy/ordering model.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;
   localparam int AET   = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          clr   = 1'b0;
   logic          we    = 1'b0;
   logic          re    = 1'b0;
   logic [DW-1:0] d     = '0;
   logic [DW-1:0] q;
   logic          q_valid, empty, full, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]   count;
   logic [11:0]   status;

   assign status = {count, empty, full, almost_full, almost_empty, overflow, underflow, q_valid};

   always #5 clk = ~clk;

   sync_fifo #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .AFULL_THRESH (AFT),
      .AEMPTY_THRESH(AET)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .we          (we),
      .d           (d),
      .re          (re),
      .q           (q),
      .q_valid     (q_valid),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            wedge;
   } entry_t;

   entry_t        mq[$];
   logic [DW-1:0] e_q;
   logic          e_qv, e_ov, e_un;
   int            edge_n;
   int            checks = 0;
   int            errors = 0;
`ifndef FIFO_FWFT_EN
   logic          pend;
   logic [DW-1:0] pend_data;
`endif

   function automatic void model_reset();
      mq.delete();
      e_q  = '0;
      e_qv = 1'b0;
      e_ov = 1'b0;
      e_un = 1'b0;
`ifndef FIFO_FWFT_EN
      pend = 1'b0;
`endif
   endfunction

   // Standard: data appears one edge after the read is accepted.
   // FWFT: a word is shown two edges after its write, but never before its predecessor leaves.
   function automatic void model_edge(input logic w, input logic r, input logic c,
                                      input logic [DW-1:0] dd);
      int     n = mq.size();
      entry_t ent;
      edge_n++;
      if (c) begin
         mq.delete();
         e_ov = 1'b0;
         e_un = 1'b0;
         e_qv = 1'b0;
`ifndef FIFO_FWFT_EN
         pend = 1'b0;
`endif
         return;
      end
      if (w && n == DEPTH) e_ov = 1'b1;
      ent.data  = dd;
      ent.wedge = edge_n;
`ifdef FIFO_FWFT_EN
      if (r && !e_qv) e_un = 1'b1;
      if (r && e_qv) void'(mq.pop_front());
      if (w && n != DEPTH) mq.push_back(ent);
      e_qv = (mq.size() > 0) && (mq[0].wedge + 2 <= edge_n);
      if (e_qv) e_q = mq[0].data;
`else
      if (r && n == 0) e_un = 1'b1;
      e_qv = pend;
      if (pend) e_q = pend_data;
      pend = r && (n != 0);
      if (pend) begin
         ent       = mq.pop_front();
         pend_data = ent.data;
         ent.data  = dd;
         ent.wedge = edge_n;
      end
      if (w && n != DEPTH) mq.push_back(ent);
`endif
   endfunction

   function automatic logic [11:0] exp_status();
      int   n = mq.size();
      logic e_empty;
`ifdef FIFO_FWFT_EN
      e_empty = ~e_qv;
`else
      e_empty = (n == 0);
`endif
      return {5'(n), e_empty, n == DEPTH, n >= AFT, n <= AET, e_ov, e_un, e_qv};
   endfunction

   task automatic cycle(input logic w, input logic r, input logic c, input logic [DW-1:0] dd);
      we  = w;
      re  = r;
      clr = c;
      d   = dd;
      model_edge(w, r, c, dd);
      @(posedge clk);
      #1;
      we  = 1'b0;
      re  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (status !== 12'b00000_1001000) begin
         $display("FAIL reset_status got=%b exp=%b", status, 12'b00000_1001000);
         errors++;
      end
      checks++;
      if (q !== 8'h00) begin
         $display("FAIL reset_q got=%h exp=00", q);
         errors++;
      end
      #9 rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (status !== exp_status()) begin
         $display("FAIL reset_idle got=%b exp=%b", status, exp_status());
         errors++;
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'(i));
         checks++;
         if ({count, full, almost_full} !== {5'(i + 1), i == DEPTH - 1, i + 1 >= AFT}) begin
            $display("FAIL fill_%0d got cnt=%0d full=%b af=%b exp cnt=%0d", i, count, full,
                     almost_full, i + 1);
            errors++;
         end
      end
      for (int i = 0; i <= DEPTH + 1; i++) begin
         cycle(1'b0, i < DEPTH, 1'b0, 8'h00);
         checks++;
         if (status !== exp_status() || q !== e_q) begin
            $display("FAIL drain_%0d got st=%b q=%h exp st=%b q=%h", i, status, q, exp_status(), e_q);
            errors++;
         end
`ifndef FIFO_FWFT_EN
         if (i > 0 && i <= DEPTH) begin
            checks++;
            if ({q_valid, q} !== {1'b1, 8'(i - 1)}) begin
               $display("FAIL drain_order_%0d got qv=%b q=%h exp q=%h", i, q_valid, q, 8'(i - 1));
               errors++;
            end
         end
`endif
      end
      checks++;
      if ({empty, count} !== {1'b1, 5'd0}) begin
         $display("FAIL drain_empty got empty=%b cnt=%0d exp empty=1 cnt=0", empty, count);
         errors++;
      end
   endtask

   task automatic test_overflow_underflow();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      cycle(1'b1, 1'b0, 1'b0, 8'hAA);
      checks++;
      if ({overflow, count} !== {1'b1, 5'd16}) begin
         $display("FAIL overflow_set got ov=%b cnt=%0d exp ov=1 cnt=16", overflow, count);
         errors++;
      end
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (overflow !== 1'b1) begin
         $display("FAIL overflow_sticky got=%b exp=1", overflow);
         errors++;
      end
      for (int i = 0; i < DEPTH + 2; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         checks++;
         if (q !== e_q || q_valid !== e_qv) begin
            $display("FAIL ovf_drain_%0d got q=%h qv=%b exp q=%h qv=%b", i, q, q_valid, e_q, e_qv);
            errors++;
         end
      end
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if ({underflow, q_valid, q} !== {1'b1, 1'b0, 8'h4F}) begin
         $display("FAIL underflow_set got un=%b qv=%b q=%h exp un=1 qv=0 q=4f", underflow, q_valid, q);
         errors++;
      end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if ({overflow, underflow, count, empty} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
         $display("FAIL clr_flags got ov=%b un=%b cnt=%0d exp ov=0 un=0 cnt=0", overflow, underflow, count);
         errors++;
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 8'(8'h85 + i));
         checks++;
         if (count !== 5'd5 || q !== e_q || q_valid !== e_qv) begin
            $display("FAIL simul_%0d got cnt=%0d q=%h qv=%b exp cnt=5 q=%h qv=%b", i, count, q, q_valid,
                     e_q, e_qv);
            errors++;
         end
`ifndef FIFO_FWFT_EN
         if (i > 0) begin
            checks++;
            if (q !== 8'(8'h80 + i - 1)) begin
               $display("FAIL simul_seq_%0d got=%h exp=%h", i, q, 8'(8'h80 + i - 1));
               errors++;
            end
         end
`endif
      end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_edge_simul();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h55);
      checks++;
      if ({count, overflow, full} !== {5'd15, 1'b1, 1'b0}) begin
         $display("FAIL full_simul got cnt=%0d ov=%b full=%b exp cnt=15 ov=1 full=0", count, overflow, full);
         errors++;
      end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h66);
      checks++;
      if ({count, underflow} !== {5'd1, 1'b1}) begin
         $display("FAIL empty_simul got cnt=%0d un=%b exp cnt=1 un=1", count, underflow);
         errors++;
      end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      checks++;
      if (count !== 5'd9) begin
         $display("FAIL mid_count got=%0d exp=9", count);
         errors++;
      end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (status !== 12'b00000_1001000 || q !== 8'h00) begin
         $display("FAIL mid_reset got st=%b q=%h exp st=000001001000 q=00", status, q);
         errors++;
      end
      #2 rst_n = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 8'h3C);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (q !== 8'h3C || status !== exp_status()) begin
         $display("FAIL mid_readback got q=%h st=%b exp q=3c st=%b", q, status, exp_status());
         errors++;
      end
   endtask

   task automatic test_random();
      logic          w, r, c;
      logic [DW-1:0] dd;
      for (int i = 0; i < 600; i++) begin
         w  = ($urandom_range(0, 9) < ((i % 200) < 100 ? 8 : 3));
         r  = ($urandom_range(0, 9) < ((i % 200) < 100 ? 3 : 8));
         c  = ($urandom_range(0, 79) == 0);
         dd = 8'($urandom);
         cycle(w, r, c, dd);
         checks++;
         if (status !== exp_status()) begin
            $display("FAIL rand_status_%0d got=%b exp=%b", i, status, exp_status());
            errors++;
         end
         checks++;
         if (q !== e_q) begin
            $display("FAIL rand_q_%0d got=%h exp=%h", i, q, e_q);
            errors++;
         end
      end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

`ifdef FIFO_FWFT_EN
   task automatic test_fwft();
      cycle(1'b1, 1'b0, 1'b0, 8'h11);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (q_valid !== 1'b0) begin
         $display("FAIL fwft_early got qv=%b exp qv=0", q_valid);
         errors++;
      end
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({q_valid, q} !== {1'b1, 8'h11}) begin
         $display("FAIL fwft_first got qv=%b q=%h exp qv=1 q=11", q_valid, q);
         errors++;
      end
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
      for (int j = 0; j < 9; j++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         checks++;
         if (q_valid !== (j < 8) || (j < 8 && q !== 8'(8'h20 + j))) begin
            $display("FAIL fwft_stream_%0d got qv=%b q=%h exp q=%h", j, q_valid, q, 8'(8'h20 + j));
            errors++;
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      edge_n = 0;
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_edge_simul();
      test_reset_mid();
`ifdef FIFO_FWFT_EN
      test_fwft();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
